// File: rtl/mips_hazard_stall_controller.sv
// Pipeline stall/flush sequencer for the 5-stage MIPS core: merges load-use stalls,
// taken-branch redirects and mult/div HI/LO occupancy into PC/IF/ID/EX controls.
module mips_hazard_stall_controller #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stallLwRead,
  input  logic                 branchTaken,
  input  logic                 exMdStart,
  input  logic                 idMdUse,
  output logic                 pcEnable,
  output logic                 ifIdEnable,
  output logic                 ifIdFlush,
  output logic                 idExFlush,
  output logic                 mdBusy,
  output logic [CNT_WIDTH-1:0] stallCycles
);

  typedef enum logic {RUN, MD_WAIT} md_state_t;

  localparam logic [7:0] MD_RELOAD = 8'(MD_LATENCY - 1);

  md_state_t  state;
  logic [7:0] mdCount;
  logic       waitState;
  logic       lwStall;
  logic       mdStall;

  assign waitState = (state == MD_WAIT);
  assign lwStall   = stallLwRead;
  assign mdStall   = idMdUse & (waitState | exMdStart);
  assign mdBusy    = ~reset & waitState;

  // A taken branch wins over any stall: the stalled ID instruction is on the wrong path.
  always_comb begin
    pcEnable   = 1'b1;
    ifIdEnable = 1'b1;
    ifIdFlush  = 1'b0;
    idExFlush  = 1'b0;
    if (reset) begin
      pcEnable   = 1'b0;
      ifIdEnable = 1'b0;
      ifIdFlush  = 1'b1;
      idExFlush  = 1'b1;
    end else if (branchTaken) begin
      ifIdFlush  = 1'b1;
      idExFlush  = 1'b1;
    end else if (lwStall | mdStall) begin
      pcEnable   = 1'b0;
      ifIdEnable = 1'b0;
      idExFlush  = 1'b1;
    end
  end

  // exMdStart is honoured even under a branch because the EX instruction is on the correct path.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      mdCount     <= 8'd0;
      stallCycles <= '0;
    end else begin
      case (state)
        RUN: begin
          if (exMdStart) begin
            state   <= MD_WAIT;
            mdCount <= MD_RELOAD;
          end
        end
        MD_WAIT: begin
          if (exMdStart) begin
            mdCount <= MD_RELOAD;
          end else if (mdCount > 8'd1) begin
            mdCount <= mdCount - 8'd1;
          end else begin
            state   <= RUN;
            mdCount <= 8'd0;
          end
        end
        default: begin
          state   <= RUN;
          mdCount <= 8'd0;
        end
      endcase

      if (!pcEnable && (stallCycles != {CNT_WIDTH{1'b1}})) begin
        stallCycles <= stallCycles + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_mips_hazard_stall_controller.sv
// Self-checking bench: directed pins plus randomized traffic against a behavioural model,
// driving a 32-bit-counter instance and a 4-bit-counter instance in parallel.
module tb_mips_hazard_stall_controller;

  localparam int LAT = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic stallLwRead = 1'b0;
  logic branchTaken = 1'b0;
  logic exMdStart = 1'b0;
  logic idMdUse = 1'b0;

  logic        pcEnable, ifIdEnable, ifIdFlush, idExFlush, mdBusy;
  logic [31:0] stallCycles;
  logic        pcEnable2, ifIdEnable2, ifIdFlush2, idExFlush2, mdBusy2;
  logic [3:0]  stallCycles2;

  int nChecks = 0;
  int nFails  = 0;

  // Model state: remaining busy cycles and the two stall counters.
  int     busyLeft = 0;
  longint bigCount = 0;
  int     smallCount = 0;

  always #5 clock = ~clock;

  mips_hazard_stall_controller #(.MD_LATENCY(LAT), .CNT_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .stallLwRead(stallLwRead), .branchTaken(branchTaken),
    .exMdStart(exMdStart), .idMdUse(idMdUse), .pcEnable(pcEnable), .ifIdEnable(ifIdEnable),
    .ifIdFlush(ifIdFlush), .idExFlush(idExFlush), .mdBusy(mdBusy), .stallCycles(stallCycles)
  );

  mips_hazard_stall_controller #(.MD_LATENCY(LAT), .CNT_WIDTH(4)) dutSat (
    .clock(clock), .reset(reset), .stallLwRead(stallLwRead), .branchTaken(branchTaken),
    .exMdStart(exMdStart), .idMdUse(idMdUse), .pcEnable(pcEnable2), .ifIdEnable(ifIdEnable2),
    .ifIdFlush(ifIdFlush2), .idExFlush(idExFlush2), .mdBusy(mdBusy2), .stallCycles(stallCycles2)
  );

  task automatic check(input string name, input longint actual, input longint expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare both DUTs against the model, then advance the model past the coming edge.
  task automatic checkOutput();
    logic expPc, expIfEn, expIfFl, expIdFl, expBusy, stall;
    expBusy = !reset && (busyLeft > 0);
    stall   = stallLwRead || (idMdUse && ((busyLeft > 0) || exMdStart));
    if (reset) begin
      expPc = 0; expIfEn = 0; expIfFl = 1; expIdFl = 1;
    end else if (branchTaken) begin
      expPc = 1; expIfEn = 1; expIfFl = 1; expIdFl = 1;
    end else if (stall) begin
      expPc = 0; expIfEn = 0; expIfFl = 0; expIdFl = 1;
    end else begin
      expPc = 1; expIfEn = 1; expIfFl = 0; expIdFl = 0;
    end
    check("pcEnable", pcEnable, expPc);
    check("ifIdEnable", ifIdEnable, expIfEn);
    check("ifIdFlush", ifIdFlush, expIfFl);
    check("idExFlush", idExFlush, expIdFl);
    check("mdBusy", mdBusy, expBusy);
    check("stallCycles", stallCycles, bigCount);
    check("pcEnable_sat", pcEnable2, expPc);
    check("mdBusy_sat", mdBusy2, expBusy);
    check("stallCycles_sat", stallCycles2, smallCount);

    if (reset) begin
      busyLeft = 0; bigCount = 0; smallCount = 0;
    end else begin
      if (exMdStart) busyLeft = LAT - 1;
      else if (busyLeft > 0) busyLeft--;
      if (!expPc) begin
        if (bigCount < 64'hFFFF_FFFF) bigCount++;
        if (smallCount < 15) smallCount++;
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic lw, input logic br,
                               input logic ex, input logic use_);
    @(posedge clock);
    #1;
    reset = rst; stallLwRead = lw; branchTaken = br; exMdStart = ex; idMdUse = use_;
    @(negedge clock);
    checkOutput();
  endtask

  initial begin
    // Reset held two cycles
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    check("rst_pcEnable", pcEnable, 0);
    check("rst_ifIdFlush", ifIdFlush, 1);
    check("rst_idExFlush", idExFlush, 1);
    applyStimulus(0, 0, 0, 0, 0);
    check("post_rst_pcEnable", pcEnable, 1);
    check("post_rst_ifIdFlush", ifIdFlush, 0);
    check("post_rst_idExFlush", idExFlush, 0);
    check("post_rst_mdBusy", mdBusy, 0);
    check("post_rst_count", stallCycles, 0);

    // Load-use bubble
    applyStimulus(0, 1, 0, 0, 0);
    check("lw_pcEnable", pcEnable, 0);
    check("lw_ifIdEnable", ifIdEnable, 0);
    check("lw_idExFlush", idExFlush, 1);
    applyStimulus(0, 0, 0, 0, 0);
    check("lw_after_pcEnable", pcEnable, 1);
    check("lw_count", stallCycles, 1);

    // Mult/div issue at T with dependent ID instruction
    applyStimulus(0, 0, 0, 1, 1);
    check("md_T_pcEnable", pcEnable, 0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 0, 0, 0, 1);
      check("md_busy_window", mdBusy, 1);
      check("md_stall_window", pcEnable, 0);
    end
    applyStimulus(0, 0, 0, 0, 1);
    check("md_T4_mdBusy", mdBusy, 0);
    check("md_T4_pcEnable", pcEnable, 1);
    check("md_count", stallCycles, 5);

    // Branch overrides load-use and mult/div stalls
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 1, 1, 0, 1);
    check("br_pcEnable", pcEnable, 1);
    check("br_ifIdFlush", ifIdFlush, 1);
    check("br_idExFlush", idExFlush, 1);
    check("br_mdBusy", mdBusy, 1);
    applyStimulus(0, 0, 0, 0, 0);
    check("br_count_unchanged", stallCycles, 5);
    applyStimulus(0, 0, 0, 0, 0);

    // Branch together with mult/div issue, then reset at mdCount==2
    applyStimulus(0, 0, 1, 1, 0);
    check("brmd_ifIdFlush", ifIdFlush, 1);
    applyStimulus(0, 0, 0, 0, 0);
    check("brmd_mdBusy", mdBusy, 1);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    check("rst_wait_mdBusy", mdBusy, 0);
    check("rst_wait_count", stallCycles, 0);

    // Twenty stalled busy cycles saturate the 4-bit counter
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, (i % 3) == 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    check("sat_small", stallCycles2, 15);
    check("sat_big", stallCycles, 20);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 20,
                    $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15,
                    $urandom_range(0, 99) < 45);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
